// File: rtl/sqrt_result_buffer.sv
// Result buffer for the pipelined sqrt core: tags operands through a latency-matched line,
// captures roots into a show-ahead FIFO with credit-based in_ready. Optional drop counter: SQRT_BUF_DROP_CNT_EN.
module sqrt_result_buffer #(
  parameter int G_WIDTH   = 8,
  parameter int G_LATENCY = 5,
  parameter int G_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [G_WIDTH/2-1:0]       root_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [G_WIDTH/2-1:0]       out_data,
  output logic [$clog2(G_DEPTH):0]   level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int RW = G_WIDTH / 2;
  localparam int AW = $clog2(G_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(G_LATENCY + 1);
  localparam int SW = $clog2(G_DEPTH + G_LATENCY + 1);

  logic [G_LATENCY-1:0] tag_q, tag_d;
  logic [FW-1:0]        inflight_q, inflight_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 out_valid_q, out_valid_d;
  logic [RW-1:0]        out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;
  logic [RW-1:0]        mem [G_DEPTH];

  logic          tag_out;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;
  logic          head_from_write;
  logic [SW-1:0] credit_sum;

  assign tag_out = tag_q[G_LATENCY-1];
  assign pop     = out_valid_q && out_ready;
  assign full    = (level_q == LW'(G_DEPTH));
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_en   = tag_out && (!full || pop);
  assign drop    = tag_out && full && !pop;

  // Credit counts both buffered roots and roots still inside the core.
  assign credit_sum = SW'(level_q) + SW'(inflight_q);
  assign in_ready   = (credit_sum < SW'(G_DEPTH));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tag_d           = G_LATENCY'({tag_q, in_valid});
    inflight_d      = inflight_q + FW'(in_valid) - FW'(tag_out);
    wr_ptr_d        = wr_ptr_q + AW'(wr_en);
    rd_ptr_d        = rd_ptr_q + AW'(pop);
    level_d         = level_q + LW'(wr_en) - LW'(pop);
    out_valid_d     = (level_d != '0);
    overflow_d      = overflow_q | drop;
    head_from_write = wr_en && (level_q == LW'(pop));
    out_data_d      = out_data_q;
    if (head_from_write) begin
      out_data_d = root_in;
    end else if (level_d != '0) begin
      out_data_d = mem[rd_ptr_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; level and the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= root_in;
    end
  end

`ifdef SQRT_BUF_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sqrt_result_buffer.sv
// Directed bench for sqrt_result_buffer; the sqrt core is modelled as a 5-stage operand delay line
// followed by an integer square root.
module tb_sqrt_result_buffer;

  localparam int G_WIDTH   = 8;
  localparam int G_LATENCY = 5;
  localparam int G_DEPTH   = 4;
`ifdef SQRT_BUF_DROP_CNT_EN
  localparam int EXP_DROPS = 2;
`else
  localparam int EXP_DROPS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] root_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;

  logic [7:0] op;
  logic [7:0] op_pipe [G_LATENCY];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sqrt_result_buffer #(
    .G_WIDTH  (G_WIDTH),
    .G_LATENCY(G_LATENCY),
    .G_DEPTH  (G_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .root_in  (root_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  function automatic logic [3:0] isqrt(input logic [7:0] x);
    int r = 0;
    for (int i = 1; i < 16; i++) begin
      if (i * i <= int'(x)) r = i;
    end
    return 4'(r);
  endfunction

  // Core model: no reset, no valid, fixed latency.
  always @(posedge clk) begin
    op_pipe[0] <= op;
    for (int i = 1; i < G_LATENCY; i++) op_pipe[i] <= op_pipe[i-1];
  end
  assign root_in = isqrt(op_pipe[G_LATENCY-1]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [7:0] s_ops   [5] = '{8'd0, 8'd1, 8'd255, 8'd200, 8'd16};
  logic [3:0] s_roots [5] = '{4'd0, 4'd1, 4'd15, 4'd14, 4'd4};
  logic [7:0] c_ops   [4] = '{8'd9, 8'd25, 8'd49, 8'd81};
  logic [3:0] c_roots [4] = '{4'd3, 4'd5, 4'd7, 4'd9};
  logic [7:0] o_ops   [6] = '{8'd4, 8'd9, 8'd16, 8'd36, 8'd64, 8'd169};
  logic [7:0] f_ops   [5] = '{8'd1, 8'd4, 8'd9, 8'd16, 8'd25};

  initial begin
    int accepted;
    logic seen_valid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_level",     32'(level),     0);
    check("rst_overflow",  32'(overflow),  0);
    check("rst_drop_cnt",  32'(drop_cnt),  0);
    check("rst_in_ready",  32'(in_ready),  1);

    // Single operand: 144 -> 12, visible after the 5th following edge.
    out_ready = 1'b1; in_valid = 1'b1; op = 8'd144;
    tick();
    in_valid = 1'b0; op = '0;
    repeat (4) tick();
    check("single_early", 32'(out_valid), 0);
    tick();
    check("single_valid", 32'(out_valid), 1);
    check("single_data",  32'(out_data),  12);
    tick();
    check("single_fall",  32'(out_valid), 0);
    check("single_level", 32'(level),     0);

    // Back-to-back stream with out_ready held high.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = s_ops[i];
      tick();
    end
    in_valid = 1'b0; op = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stream_valid%0d", i), 32'(out_valid), 1);
      check($sformatf("stream_data%0d", i),  32'(out_data),  32'(s_roots[i]));
    end
    tick();
    check("stream_end",      32'(out_valid), 0);
    check("stream_overflow", 32'(overflow),  0);

    // Credit stall: issue only while in_ready, consumer stalled.
    out_ready = 1'b0; accepted = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = in_ready;
      if (in_ready) begin
        op = c_ops[accepted];
        accepted++;
      end
      tick();
    end
    in_valid = 1'b0; op = '0;
    check("credit_accepted", 32'(accepted), 4);
    check("credit_in_ready", 32'(in_ready), 0);
    check("credit_level",    32'(level),    4);
    check("credit_head",     32'(out_data), 3);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("credit_data%0d", i), 32'(out_data), 32'(c_roots[i]));
    end
    check("credit_ready_back", 32'(in_ready), 1);
    tick();
    check("credit_drained", 32'(out_valid), 0);
    check("credit_level0",  32'(level),     0);

    // Forced overflow: 6 operands ignoring in_ready, the last two are dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; op = o_ops[i];
      tick();
    end
    in_valid = 1'b0; op = '0;
    repeat (6) tick();
    check("ovf_level",    32'(level),    4);
    check("ovf_flag",     32'(overflow), 1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'(EXP_DROPS));
    check("ovf_in_ready", 32'(in_ready), 0);
    check("ovf_head",     32'(out_data), 2);
    out_ready = 1'b1;
    tick(); check("ovf_data1", 32'(out_data), 3);
    tick(); check("ovf_data2", 32'(out_data), 4);
    tick(); check("ovf_data3", 32'(out_data), 6);
    tick(); check("ovf_empty", 32'(out_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Full FIFO: write due and pop on the same edge.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = f_ops[i];
      tick();
    end
    in_valid = 1'b0; op = '0;
    repeat (4) tick();
    check("full_level_pre", 32'(level), 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_level_post", 32'(level),    4);
    check("full_no_drop",    32'(drop_cnt), 32'(EXP_DROPS));
    check("full_head",       32'(out_data), 2);
    out_ready = 1'b1;
    tick(); check("full_data3", 32'(out_data), 3);
    tick(); check("full_data4", 32'(out_data), 4);
    tick(); check("full_data5", 32'(out_data), 5);
    tick(); check("full_empty", 32'(out_valid), 0);

    // Reset mid-operation: three operands in flight are forgotten.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 8'(49 + 15 * i);
      tick();
    end
    in_valid = 1'b0; op = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 1);
    seen_valid = 1'b0;
    repeat (8) begin
      tick();
      seen_valid |= out_valid;
    end
    check("mid_rst_no_valid", 32'(seen_valid), 0);
    check("mid_rst_out_data", 32'(out_data),   0);
    check("mid_rst_level",    32'(level),      0);
    check("mid_rst_overflow", 32'(overflow),   0);
    check("mid_rst_drop_cnt", 32'(drop_cnt),   0);
    check("mid_rst_ready",    32'(in_ready),   1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_result_buffer.md
# sqrt_result_buffer

Downstream companion to the pipelined `sqrt` core. It carries a valid tag alongside each operand through a delay line matched to the core's fixed latency, because the core has no valid or reset. It captures each tagged root into a small FIFO and presents results on a ready/valid output, with credit-based backpressure toward the operand source. It also supports overflow detection.

## Interface
- `G_WIDTH`, default 8: operand width of the `sqrt` core, even. The root is `G_WIDTH/2` bits.
- `G_LATENCY`, default 5: core latency in clocks, `G_WIDTH/2+1`. Must be at least 1.
- `G_DEPTH`, default 4: FIFO entries. Must be a power of 2 and at least 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: the operand on the core's `data_in` this cycle is a real request.
- `in_ready`  out  1: high when a new operand can be issued without risk of drop.
- `root_in`  in  `G_WIDTH/2`: the core's `data_out`.
- `out_valid`  out  1: `out_data` holds the FIFO head.
- `out_ready`  in  1: consumer accepts the head.
- `out_data`  out  `G_WIDTH/2`: oldest buffered root.
- `level`  out  `$clog2(G_DEPTH)+1`: number of FIFO entries in use.
- `overflow`  out  1: sticky; a result was dropped.
- `drop_cnt`  out  8: saturating count of dropped results (see Configuration).

## Operation
- **Tag line**
  - Shift register of `G_LATENCY` bits.
  - A tag is sampled from `in_valid` every edge.
  - The tag emerging from the line is aligned with `root_in`.
- **Write**
  - When the emerging tag is 1, `root_in` is written at that edge.
  - This corresponds to the operand that had `in_valid` high `G_LATENCY` edges earlier.
- **Pop**
  - Occurs on an edge where `out_valid && out_ready`.
- **Counters**
  - `inflight` counts tags currently in the line, 0 to `G_LATENCY`.
  - `level` counts FIFO occupancy, 0 to `G_DEPTH`.
- **Credit**
  - `in_ready = (level + inflight) < G_DEPTH`.
  - Decoded from registers only; no combinational path from any input.
- **Upstream behaviour with `in_ready` low**
  - Upstream must hold `in_valid` low while `in_ready` is low.
  - If it does not, the tag is still accepted; loss is handled at write time.
- **Drop**
  - Happens when a write is due, `level == G_DEPTH`, and no pop occurs at the same edge.
  - The root is discarded, `overflow` is set, and `drop_cnt` increments.
- **Full FIFO, simultaneous write and pop**
  - Both occur and `level` is unchanged. No drop.
- **Empty FIFO, simultaneous write**
  - The pop qualifier is 0 because `out_valid` is 0, so the write lands.
  - `out_valid` rises the next cycle. There is no bypass.
- **Pointers**
  - `$clog2(G_DEPTH)`-bit read and write pointers, wrapping naturally modulo `G_DEPTH`.
- **Output registers**
  - `out_data` and `out_valid` are driven from FIFO state (show-ahead) and update only at edges.
- **State per entry**
  - Each entry is either EMPTY or FULL. `level` is the sole occupancy state; there is no separate FSM.

## Timing
- **Reset** (synchronous `rst`) clears:
  - the tag line and `inflight`,
  - the pointers and `level`,
  - `out_valid` and `out_data` to 0,
  - `overflow` and `drop_cnt` to 0.
- **Reset mid-operation**
  - All in-flight operands are forgotten; the core itself is not reset.
  - Roots emerging after reset deassertion are ignored, because their tags are 0.
  - `in_ready` is 1 on the first cycle after reset.
- **Latency**
  - `in_valid` sampled at edge k means the root is written at edge k+`G_LATENCY`.
  - `out_valid` is high from cycle k+`G_LATENCY`+1 if the FIFO was empty.
- **Throughput**
  - One result per clock while `out_ready` is held high.
- **Handshake hold**
  - `out_data` is stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a pop.
- **`inflight` update**
  - +1 when the entering tag is 1; −1 when the emerging tag is 1.
  - Both at once leaves it unchanged.

## Configuration
- `SQRT_BUF_DROP_CNT_EN` defined:
  - `drop_cnt` is an 8-bit saturating counter, holding at 255.
  - It clears on `rst`.
- Not defined:
  - No counter register is built and `drop_cnt` is tied to 0.
  - The `overflow` flag behaves identically in both builds.

## Test plan
All scenarios use `G_WIDTH=8`, `G_LATENCY=5`, `G_DEPTH=4`, with the real `sqrt` core attached.

- **Single operand:** issue 144 at edge 0, `out_ready=1` → `out_valid` rises in cycle 6 with `out_data=12`, then falls after 1 cycle.
- **Back-to-back stream:** operands 0, 1, 255, 200, 16 on consecutive edges with `out_ready=1` → outputs 0, 1, 15, 14, 4 on consecutive cycles, no gaps, `overflow=0`.
- **Credit stall:** hold `out_ready=0` and issue only while `in_ready` → exactly 4 accepted, `in_ready=0` from then, `level` reaches 4. Raise `out_ready` → results appear in order and `in_ready` returns high.
- **Forced overflow:** `out_ready=0` and 6 operands ignoring `in_ready` → `level=4`, `overflow=1`, `drop_cnt=2` (0 when the macro is undefined). The 4 oldest roots are retained.
- **Full FIFO with simultaneous write and pop:** `level=4`, a write due, and `out_ready=1` at the same edge → no drop, `level` stays 4.
- **Reset mid-operation:** issue 3 operands, assert `rst` for 1 cycle 2 edges later → no `out_valid` ever follows, and all outputs read their reset values.
